// File: rtl/pc_ras_unit.sv
// Program-counter unit: fetch PC register, next-PC source mux and an optional
// circular return-address stack, built only when PC_RAS_EN is defined.
module pc_ras_unit #(
    parameter int              PC_W      = 30,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         pcEN,
    input  logic [2:0]                   pcSel,
    input  logic                         isCall,
    input  logic                         bpFlush,
    input  logic [PC_W-1:0]              rpc,
    input  logic [PC_W-1:0]              br_a,
    input  logic [PC_W-1:0]              bp_a,
    input  logic [PC_W-1:0]              rdat,
    input  logic [25:0]                  immJ26,
    output logic [PC_W-1:0]              cpc,
    output logic [PC_W-1:0]              npc,
    output logic [PC_W-1:0]              next_pc,
    output logic [PC_W-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_miss
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_J    = 3'd2,
        SEL_JR   = 3'd3,
        SEL_PRED = 3'd4,
        SEL_RAS  = 3'd5
    } sel_e;

    logic [PC_W-1:0] jump_tgt;

    assign npc      = cpc + PC_W'(1);
    assign jump_tgt = {npc[PC_W-1:26], immJ26};

    // Redirect from a mispredict overrides every other source.
    always_comb begin
        next_pc = npc;
        case (pcSel)
            SEL_BR:   next_pc = br_a;
            SEL_J:    next_pc = jump_tgt;
            SEL_JR:   next_pc = rdat;
            SEL_PRED: next_pc = bp_a;
`ifdef PC_RAS_EN
            SEL_RAS:  next_pc = ras_empty ? npc : ras_top;
`else
            SEL_RAS:  next_pc = rdat;
`endif
            default:  next_pc = npc;
        endcase
        if (bpFlush)
            next_pc = rpc;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            cpc <= RESET_PC;
        else if (bpFlush || pcEN)
            cpc <= next_pc;
    end

`ifdef PC_RAS_EN
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(RAS_DEPTH)) ? c : c + CW'(1);
    endfunction

    logic [PC_W-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   count;
    logic            miss;
    logic            advance;
    logic            push;
    logic            pop;

    assign advance   = pcEN && !bpFlush;
    assign push      = advance && isCall;
    assign pop       = advance && (pcSel == SEL_RAS);
    assign top_idx   = ptr - PW'(1);
    assign ras_top   = (count == '0) ? '0 : stack[top_idx];
    assign ras_count = count;
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));
    assign ras_miss  = miss;

    // A full push overwrites the oldest slot because the pointer simply wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr   <= '0;
            count <= '0;
            miss  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++)
                stack[i] <= '0;
        end else if (bpFlush) begin
            ptr   <= '0;
            count <= '0;
            miss  <= 1'b0;
        end else if (pcEN) begin
            miss <= pop && (count == '0);
            if (push && pop && (count != '0)) begin
                stack[top_idx] <= npc;
            end else if (push) begin
                stack[ptr] <= npc;
                ptr        <= ptr + PW'(1);
                count      <= sat_inc(count);
            end else if (pop && (count != '0)) begin
                ptr   <= top_idx;
                count <= count - CW'(1);
            end
        end else begin
            miss <= 1'b0;
        end
    end
`else
    logic unused_call;

    assign unused_call = isCall;
    assign ras_top     = '0;
    assign ras_count   = '0;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
    assign ras_miss    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit; RAS scenarios run when PC_RAS_EN is defined,
// otherwise the stack-less behaviour is checked.
module tb_pc_ras_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pcEN;
    logic [2:0]  pcSel;
    logic        isCall;
    logic        bpFlush;
    logic [29:0] rpc;
    logic [29:0] br_a;
    logic [29:0] bp_a;
    logic [29:0] rdat;
    logic [25:0] immJ26;
    logic [29:0] cpc;
    logic [29:0] npc;
    logic [29:0] next_pc;
    logic [29:0] ras_top;
    logic [3:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_miss;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    pc_ras_unit dut (
        .CLK(CLK), .RST(RST), .pcEN(pcEN), .pcSel(pcSel), .isCall(isCall),
        .bpFlush(bpFlush), .rpc(rpc), .br_a(br_a), .bp_a(bp_a), .rdat(rdat),
        .immJ26(immJ26), .cpc(cpc), .npc(npc), .next_pc(next_pc),
        .ras_top(ras_top), .ras_count(ras_count), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_miss(ras_miss)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; pcEN = 1'b0; pcSel = 3'd0; isCall = 1'b0; bpFlush = 1'b0;
        rpc = '0; br_a = '0; bp_a = '0; rdat = '0; immJ26 = '0;
        step();
        RST = 1'b0;
        #1;
        check("rst_cpc", cpc, 0);
        check("rst_count", ras_count, 0);
        check("rst_empty", ras_empty, 1);
        check("rst_miss", ras_miss, 0);

        // Sequential run
        pcEN = 1'b1;
        #1;
        check("seq_npc", npc, 1);
        check("seq_next", next_pc, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_cpc", cpc, i);
        end

        // Each source in turn
        pcSel = 3'd1; br_a = 30'h10; step();
        check("br_cpc10", cpc, 32'h10);
        br_a = 30'h200; #1;
        check("br_next", next_pc, 32'h200);
        step();
        check("br_cpc", cpc, 32'h200);
        pcSel = 3'd2; immJ26 = 26'h0000ABC; step();
        check("j_low", cpc, 32'h0000ABC);
        pcSel = 3'd1; br_a = 30'h2C000005; step();
        pcSel = 3'd2; immJ26 = 26'h123; #1;
        check("j_upper_next", next_pc, 32'h2C000123);
        step();
        check("j_upper_cpc", cpc, 32'h2C000123);
        pcSel = 3'd3; rdat = 30'h3F0; step();
        check("jr_cpc", cpc, 32'h3F0);
        pcSel = 3'd4; bp_a = 30'h44; step();
        check("pred_cpc", cpc, 32'h44);
        pcSel = 3'd6; step();
        check("sel6_seq", cpc, 32'h45);

`ifdef PC_RAS_EN
        // Call then return
        pcSel = 3'd1; br_a = 30'h100; step();
        pcSel = 3'd0; isCall = 1'b1; step();
        check("call_top", ras_top, 32'h101);
        check("call_count", ras_count, 1);
        isCall = 1'b0; step();
        pcSel = 3'd5; #1;
        check("ret_next", next_pc, 32'h101);
        step();
        check("ret_cpc", cpc, 32'h101);
        check("ret_count", ras_count, 0);
        check("ret_nomiss", ras_miss, 0);

        // Overflow: push npc 1..9 from cpc 0..8
        pcSel = 3'd0; bpFlush = 1'b1; rpc = 30'h0; step();
        bpFlush = 1'b0; isCall = 1'b1;
        for (int i = 0; i < 9; i++) step();
        isCall = 1'b0;
        check("ovf_count", ras_count, 8);
        check("ovf_full", ras_full, 1);
        check("ovf_top", ras_top, 9);
        pcSel = 3'd5;
        for (int i = 9; i >= 2; i--) begin
            #1;
            check("pop_next", next_pc, i);
            step();
        end
        check("pop_count", ras_count, 0);
        check("pop_empty", ras_empty, 1);
        check("unf_next", next_pc, 3);
        step();
        check("unf_cpc", cpc, 3);
        check("unf_miss", ras_miss, 1);
        pcSel = 3'd0; step();
        check("unf_miss_clr", ras_miss, 0);

        // Simultaneous push and pop with count=2, top=0x50, npc=0x81
        bpFlush = 1'b1; rpc = 30'h2F; step();
        bpFlush = 1'b0; isCall = 1'b1; step();
        isCall = 1'b0; pcSel = 3'd1; br_a = 30'h4F; step();
        isCall = 1'b1; pcSel = 3'd0; step();
        check("pp_pre_top", ras_top, 32'h50);
        check("pp_pre_count", ras_count, 2);
        isCall = 1'b0; pcSel = 3'd1; br_a = 30'h80; step();
        isCall = 1'b1; pcSel = 3'd5; #1;
        check("pp_next", next_pc, 32'h50);
        step();
        check("pp_top", ras_top, 32'h81);
        check("pp_count", ras_count, 2);
        check("pp_cpc", cpc, 32'h50);
        isCall = 1'b0; step();
        check("pp_pop_cpc", cpc, 32'h81);
        check("pp_pop_top", ras_top, 32'h30);
        exp_cnt = 1;
`else
        // Without the stack, RAS select acts as JR and calls are ignored
        pcSel = 3'd5; isCall = 1'b1; rdat = 30'h555; #1;
        check("noras_next", next_pc, 32'h555);
        step();
        check("noras_cpc", cpc, 32'h555);
        check("noras_top", ras_top, 0);
        check("noras_count", ras_count, 0);
        check("noras_empty", ras_empty, 1);
        check("noras_full", ras_full, 0);
        check("noras_miss", ras_miss, 0);
        isCall = 1'b0;
        exp_cnt = 0;
`endif

        // Stall holds everything
        pcSel = 3'd1; br_a = 30'h60; step();
        pcEN = 1'b0; br_a = 30'h999; isCall = 1'b1; step();
        check("stall_cpc", cpc, 32'h60);
        check("stall_count", ras_count, exp_cnt);
        check("stall_miss", ras_miss, 0);

        // Flush overrides a stall
        bpFlush = 1'b1; rpc = 30'h77; #1;
        check("flush_next", next_pc, 32'h77);
        step();
        check("flush_cpc", cpc, 32'h77);
        check("flush_count", ras_count, 0);
        bpFlush = 1'b0; isCall = 1'b0; pcEN = 1'b1;

        // Wrap at the top of the address space
        br_a = 30'h3FFFFFFF; step();
        check("wrap_npc", npc, 0);
        pcSel = 3'd0; step();
        check("wrap_cpc", cpc, 0);

        // Reset mid-run has priority over flush
        RST = 1'b1; bpFlush = 1'b1; rpc = 30'h123; step();
        RST = 1'b0; bpFlush = 1'b0; #1;
        check("rst2_cpc", cpc, 0);
        check("rst2_count", ras_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
